// File: rtl/jtag_mem_access_pkg.sv
// Shared types and constants for the JTAG memory access command engine.
package jtag_mem_access_pkg;

  localparam int unsigned FRAME_W  = 34;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned OP_LSB   = 32;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Command frame as it sits in the shift register: op in the MSBs, data in the LSBs.
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/jtag_shift_reg.sv
// 34-bit LSB-first command/response shift register with parallel load of the data field.
module jtag_shift_reg
  import jtag_mem_access_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              shift_en_i,
  input  logic              shift_bit_i,
  input  logic              load_en_i,
  input  logic [DATA_W-1:0] load_data_i,
  output frame_t            frame_o
);

  frame_t frame_q;
  frame_t frame_d;

  // Next frame: read data capture has priority over shifting.
  always_comb begin
    frame_d = frame_q;
    if (load_en_i) begin
      frame_d.data = load_data_i;
    end else if (shift_en_i) begin
      frame_d = frame_t'({shift_bit_i, frame_q[FRAME_W-1:1]});
    end
  end

  // Frame register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/jtag_mem_access.sv
// Command engine: executes one read or write on the memory bus per shifted-in frame.
module jtag_mem_access
  import jtag_mem_access_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_shiftEn,
  input  logic              i_shiftBit,
  output logic              o_shiftBit,
  input  logic              i_cmdGo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_jtagAddr,
  output logic [DATA_W-1:0] o_jtagDataIn,
  output logic              o_jtagWr,
  output logic              o_jtagEn,
  input  logic [DATA_W-1:0] i_memData
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               en_q, en_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               shift_en;
  logic               load_en;
  frame_t             frame;

  jtag_shift_reg u_shift_reg (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .shift_en_i  (shift_en),
    .shift_bit_i (i_shiftBit),
    .load_en_i   (load_en),
    .load_data_i (i_memData),
    .frame_o     (frame)
  );

  // Next-state logic; bus outputs are derived from the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shift_en = 1'b0;
    load_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmdGo) begin
          op_d = frame.op;
          if ((frame.op == OP_READ) || (frame.op == OP_WRITE)) begin
            state_d = ST_ACCESS;
            cnt_d   = CNT_W'(MEM_WAIT);
          end else begin
            state_d = ST_DONE;
            if (frame.op == OP_RSVD) begin
              err_d = 1'b1;
            end
          end
        end else begin
          shift_en = i_shiftEn;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
          load_en = (op_q == OP_READ);
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    en_d   = (state_d == ST_ACCESS);
    wr_d   = en_d && (op_d == OP_WRITE);
    addr_d = en_d ? frame.addr : '0;
    din_d  = wr_d ? frame.data : '0;
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign o_shiftBit   = frame.data[0];
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_jtagEn     = en_q;
  assign o_jtagWr     = wr_q;
  assign o_jtagAddr   = addr_q;
  assign o_jtagDataIn = din_q;

endmodule

// File: tb/tb_jtag_mem_access.sv
// Bench: two engines (MEM_WAIT=1 and 3) on shared stimulus, checked against a frame-level model.
module tb_jtag_mem_access;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_shiftEn;
  logic        i_shiftBit;
  logic        i_cmdGo;

  logic        sb   [2];
  logic        busy [2];
  logic        done [2];
  logic        err  [2];
  logic [15:0] addr [2];
  logic [15:0] din  [2];
  logic        wr   [2];
  logic        en   [2];
  logic [15:0] mdat [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  always #5 i_clk = ~i_clk;

  // Memory content seen by both engines: a fixed function of the address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  assign mdat[0] = memf(addr[0]);
  assign mdat[1] = memf(addr[1]);

  jtag_mem_access #(.MEM_WAIT(1)) u_dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_shiftEn(i_shiftEn), .i_shiftBit(i_shiftBit),
    .o_shiftBit(sb[0]), .i_cmdGo(i_cmdGo), .o_busy(busy[0]), .o_done(done[0]),
    .o_err(err[0]), .o_jtagAddr(addr[0]), .o_jtagDataIn(din[0]), .o_jtagWr(wr[0]),
    .o_jtagEn(en[0]), .i_memData(mdat[0])
  );

  jtag_mem_access #(.MEM_WAIT(3)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_shiftEn(i_shiftEn), .i_shiftBit(i_shiftBit),
    .o_shiftBit(sb[1]), .i_cmdGo(i_cmdGo), .o_busy(busy[1]), .o_done(done[1]),
    .o_err(err[1]), .o_jtagAddr(addr[1]), .o_jtagDataIn(din[1]), .o_jtagWr(wr[1]),
    .o_jtagEn(en[1]), .i_memData(mdat[1])
  );

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: frame contents plus "cycles since go" k (0 = idle), per engine.
  int          mw      [2] = '{1, 3};
  logic [33:0] m_frame [2] = '{34'd0, 34'd0};
  logic [1:0]  m_op    [2] = '{2'd0, 2'd0};
  int          m_k     [2] = '{0, 0};
  bit          m_err   [2] = '{1'b0, 1'b0};

  function automatic bit m_rw(input int d);
    return (m_op[d] == 2'b01) || (m_op[d] == 2'b10);
  endfunction

  function automatic int m_len(input int d);
    return m_rw(d) ? mw[d] + 3 : 1;
  endfunction

  always @(posedge i_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (i_rst) begin
        m_frame[d] = '0; m_op[d] = '0; m_k[d] = 0; m_err[d] = 1'b0;
      end else if (m_k[d] == 0) begin
        if (i_cmdGo) begin
          m_op[d] = m_frame[d][33:32];
          m_k[d]  = 1;
          if (m_op[d] == 2'b11) m_err[d] = 1'b1;
        end else if (i_shiftEn) begin
          m_frame[d] = {i_shiftBit, m_frame[d][33:1]};
        end
      end else begin
        if (m_op[d] == 2'b01 && m_k[d] == mw[d] + 1)
          m_frame[d][15:0] = memf(m_frame[d][31:16]);
        m_k[d] = (m_k[d] == m_len(d)) ? 0 : m_k[d] + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        logic x_en, x_wr;
        x_en = m_rw(d) && (m_k[d] >= 1) && (m_k[d] <= mw[d] + 1);
        x_wr = x_en && (m_op[d] == 2'b10);
        chk($sformatf("d%0d busy", d), busy[d], m_k[d] != 0);
        chk($sformatf("d%0d done", d), done[d], (m_k[d] != 0) && (m_k[d] == m_len(d)));
        chk($sformatf("d%0d err", d), err[d], m_err[d]);
        chk($sformatf("d%0d en", d), en[d], x_en);
        chk($sformatf("d%0d wr", d), wr[d], x_wr);
        chk($sformatf("d%0d addr", d), addr[d], x_en ? m_frame[d][31:16] : 16'h0);
        chk($sformatf("d%0d din", d), din[d], x_wr ? m_frame[d][15:0] : 16'h0);
        chk($sformatf("d%0d tdo", d), sb[d], m_frame[d][0]);
      end
    end
  end

  // Apply inputs for one clock edge, return in the following cycle.
  task automatic step(input logic se, input logic b, input logic go);
    i_shiftEn = se; i_shiftBit = b; i_cmdGo = go;
    @(negedge i_clk);
  endtask

  task automatic shift_frame(input logic [1:0] op, input logic [15:0] a, input logic [15:0] dt);
    logic [33:0] f;
    f = {op, a, dt};
    for (int i = 0; i < 34; i++) step(1'b1, f[i], 1'b0);
  endtask

  task automatic shift_out(output logic [15:0] v0, output logic [15:0] v1);
    for (int i = 0; i < 16; i++) begin
      v0[i] = sb[0]; v1[i] = sb[1];
      step(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step(1'b0, 1'b0, 1'b0);
    while ((busy[0] || busy[1]) && n < 40) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_idle timeout", busy[0] | busy[1], 1'b0);
  endtask

  initial begin
    logic [15:0] v0, v1;
    int nd0, nd1;
    i_rst = 1'b1; i_shiftEn = 1'b0; i_shiftBit = 1'b0; i_cmdGo = 1'b0;
    @(negedge i_clk);
    cmp_on = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("reset busy", busy[d], 1'b0);
      chk("reset en", en[d], 1'b0);
      chk("reset tdo", sb[d], 1'b0);
    end
    i_rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Write 0xBEEF to 0x1234.
    shift_frame(2'b10, 16'h1234, 16'hBEEF);
    step(1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      chk("wr en0", en[0], c <= 2);
      chk("wr wr0", wr[0], c <= 2);
      if (c <= 2) begin
        chk("wr addr0", addr[0], 16'h1234);
        chk("wr din0", din[0], 16'hBEEF);
      end
      chk("wr done0", done[0], c == 4);
      chk("wr done1", done[1], c == 6);
      step(1'b0, 1'b0, 1'b0);
    end
    wait_idle();
    shift_out(v0, v1);
    chk("wr frame0", v0, 16'hBEEF);
    chk("wr frame1", v1, 16'hBEEF);

    // Read from 0x00FF.
    wait_idle();
    shift_frame(2'b01, 16'h00FF, 16'h0000);
    step(1'b0, 1'b0, 1'b1);
    wait_idle();
    shift_out(v0, v1);
    chk("rd tdo0", v0, 16'hA5C3);
    chk("rd tdo1", v1, 16'hA5C3);

    // NOP then reserved opcode.
    wait_idle();
    shift_frame(2'b00, 16'h5555, 16'h5555);
    step(1'b0, 1'b0, 1'b1);
    chk("nop done0", done[0], 1'b1);
    chk("nop done1", done[1], 1'b1);
    chk("nop en0", en[0], 1'b0);
    chk("nop err0", err[0], 1'b0);
    wait_idle();
    shift_frame(2'b11, 16'h0001, 16'h0002);
    step(1'b0, 1'b0, 1'b1);
    chk("rsvd done0", done[0], 1'b1);
    chk("rsvd err0", err[0], 1'b1);
    chk("rsvd err1", err[1], 1'b1);
    wait_idle();
    shift_frame(2'b01, 16'h0010, 16'h0000);
    step(1'b0, 1'b0, 1'b1);
    wait_idle();
    chk("err sticky0", err[0], 1'b1);
    chk("err sticky1", err[1], 1'b1);

    // Go and shift pulsed while busy are ignored.
    shift_frame(2'b01, 16'h4321, 16'h0000);
    step(1'b0, 1'b0, 1'b1);
    nd0 = 0; nd1 = 0;
    for (int c = 1; c <= 12; c++) begin
      nd0 += int'(done[0]); nd1 += int'(done[1]);
      step(c <= 2, 1'b1, c <= 2);
    end
    chk("busy dones0", 34'(nd0), 34'd1);
    chk("busy dones1", 34'(nd1), 34'd1);
    shift_out(v0, v1);
    chk("busy rd0", v0, 16'h7B80);
    chk("busy rd1", v1, 16'h7B80);

    // Go and shift in the same idle cycle: go wins, shift bit dropped.
    wait_idle();
    shift_frame(2'b01, 16'h0F0F, 16'h0000);
    step(1'b1, 1'b1, 1'b1);
    chk("sim addr0", addr[0], 16'h0F0F);
    chk("sim addr1", addr[1], 16'h0F0F);
    wait_idle();
    shift_out(v0, v1);
    chk("sim rd0", v0, 16'h55CC);
    chk("sim rd1", v1, 16'h55CC);

    // Reset in the middle of a write.
    wait_idle();
    shift_frame(2'b10, 16'hCAFE, 16'h1357);
    step(1'b0, 1'b0, 1'b1);
    chk("rst pre wr0", wr[0], 1'b1);
    i_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("rst wr", wr[d], 1'b0);
      chk("rst en", en[d], 1'b0);
      chk("rst busy", busy[d], 1'b0);
      chk("rst tdo", sb[d], 1'b0);
      chk("rst err", err[d], 1'b0);
    end
    i_rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      i_rst = ($urandom_range(0, 149) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0);
    end
    i_rst = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
